// File: rtl/guess_sequencer.sv
// Job controller for the brute-force cracking datapath: sweeps the guess
// generator over a length range, qualifies its output and latches the first match.
module guess_sequencer #(
  parameter int GEN_LATENCY  = 1,
  parameter int HASH_LATENCY = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic [2:0]   charset,
  input  logic [4:0]   min_len,
  input  logic [4:0]   max_len,
  output logic [2:0]   gen_charset,
  output logic [4:0]   gen_guesslen,
  output logic         gen_reset,
  input  logic         gen_done,
  output logic         hash_valid,
  input  logic         hash_match,
  input  logic [127:0] hash_match_guess,
  output logic         busy,
  output logic         found,
  output logic [127:0] found_guess,
  output logic         exhausted,
  output logic         error,
  output logic [47:0]  guess_count
);

  localparam int CNT_MAX = (HASH_LATENCY > GEN_LATENCY + 1) ? HASH_LATENCY : GEN_LATENCY + 1;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PRIME, S_RUN, S_NEXT, S_DRAIN
  } state_e;

  state_e         state_q;
  logic [CW-1:0]  cnt_q;
  logic [4:0]     cur_len_q;
  logic [4:0]     max_len_q;
  logic [2:0]     charset_q;
  logic           found_q;
  logic           exhausted_q;
  logic           error_q;
  logic [127:0]   found_guess_q;
  logic [47:0]    guess_count_q;
  logic           job_illegal;

  assign job_illegal = (charset > 3'd5) || (min_len == 5'd0) ||
                       (max_len > 5'd16) || (min_len > max_len);

  // The generator only runs while priming or running; every other state holds it in reset.
  assign gen_reset    = (state_q != S_PRIME) && (state_q != S_RUN);
  assign hash_valid   = (state_q == S_RUN) && !gen_done;
  assign busy         = (state_q != S_IDLE);
  assign gen_charset  = charset_q;
  assign gen_guesslen = cur_len_q;
  assign found        = found_q;
  assign found_guess  = found_guess_q;
  assign exhausted    = exhausted_q;
  assign error        = error_q;
  assign guess_count  = guess_count_q;

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order in this block.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      cur_len_q     <= '0;
      max_len_q     <= '0;
      charset_q     <= '0;
      found_q       <= 1'b0;
      exhausted_q   <= 1'b0;
      error_q       <= 1'b0;
      found_guess_q <= '0;
      guess_count_q <= '0;
    end else begin
      if (hash_valid) guess_count_q <= guess_count_q + 48'd1;

      if (state_q == S_IDLE) begin
        if (start) begin
          if (job_illegal) begin
            error_q <= 1'b1;
          end else begin
            charset_q     <= charset;
            cur_len_q     <= min_len;
            max_len_q     <= max_len;
            found_q       <= 1'b0;
            exhausted_q   <= 1'b0;
            error_q       <= 1'b0;
            guess_count_q <= '0;
            state_q       <= S_LOAD;
          end
        end
      end else if (hash_match) begin
        found_guess_q <= hash_match_guess;
        found_q       <= 1'b1;
        state_q       <= S_IDLE;
      end else if (stop) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_LOAD: begin
            cnt_q   <= '0;
            state_q <= S_PRIME;
          end
          S_PRIME: begin
            if (cnt_q == CW'(GEN_LATENCY)) state_q <= S_RUN;
            else                           cnt_q   <= cnt_q + 1'b1;
          end
          S_RUN: begin
            if (gen_done) state_q <= S_NEXT;
          end
          S_NEXT: begin
            if (cur_len_q == max_len_q) begin
              cnt_q   <= '0;
              state_q <= S_DRAIN;
            end else begin
              cur_len_q <= cur_len_q + 5'd1;
              state_q   <= S_LOAD;
            end
          end
          S_DRAIN: begin
            if (cnt_q == CW'(HASH_LATENCY - 1)) begin
              exhausted_q <= 1'b1;
              state_q     <= S_IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_guess_sequencer.sv
// Directed bench for guess_sequencer: inputs driven and outputs sampled on the
// falling edge; the bench plays the generator by timing gen_done itself.
module tb_guess_sequencer;

  logic         clk = 1'b0;
  logic         reset, start, stop, gen_done, hash_match;
  logic [2:0]   charset;
  logic [4:0]   min_len, max_len;
  logic [127:0] hash_match_guess;
  logic [2:0]   gen_charset;
  logic [4:0]   gen_guesslen;
  logic         gen_reset, hash_valid, busy, found, exhausted, error;
  logic [127:0] found_guess;
  logic [47:0]  guess_count;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [127:0] DOG = 128'h646f67;
  localparam logic [127:0] CAT = 128'h636174;
  localparam logic [127:0] ZZ  = 128'h7a7a;

  guess_sequencer #(.GEN_LATENCY(1), .HASH_LATENCY(64)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .stop             (stop),
    .charset          (charset),
    .min_len          (min_len),
    .max_len          (max_len),
    .gen_charset      (gen_charset),
    .gen_guesslen     (gen_guesslen),
    .gen_reset        (gen_reset),
    .gen_done         (gen_done),
    .hash_valid       (hash_valid),
    .hash_match       (hash_match),
    .hash_match_guess (hash_match_guess),
    .busy             (busy),
    .found            (found),
    .found_guess      (found_guess),
    .exhausted        (exhausted),
    .error            (error),
    .guess_count      (guess_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"},      128'(busy),         128'd0);
    check({tag, "_found"},     128'(found),        128'd0);
    check({tag, "_exhausted"}, 128'(exhausted),    128'd0);
    check({tag, "_error"},     128'(error),        128'd0);
    check({tag, "_hvalid"},    128'(hash_valid),   128'd0);
    check({tag, "_genrst"},    128'(gen_reset),    128'd1);
    check({tag, "_fguess"},    found_guess,        128'd0);
    check({tag, "_count"},     128'(guess_count),  128'd0);
    check({tag, "_len"},       128'(gen_guesslen), 128'd0);
    check({tag, "_cset"},      128'(gen_charset),  128'd0);
  endtask

  // Pulse start for one cycle; returns on the falling edge after the launch.
  task automatic launch(input logic [2:0] cs, input logic [4:0] mn, input logic [4:0] mx);
    start = 1'b1; charset = cs; min_len = mn; max_len = mx;
    tick();
    start = 1'b0;
  endtask

  // Called on the first RUN falling edge: n valid guesses, then gen_done.
  // Returns on the falling edge of the NEXT cycle.
  task automatic run_len(input int n, input string tag);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      if (hash_valid !== 1'b1) bad++;
      tick();
    end
    gen_done = 1'b1;
    #1;
    check({tag, "_valid_on_done"}, 128'(hash_valid), 128'd0);
    tick();
    gen_done = 1'b0;
    check({tag, "_valid_cycles"}, 128'(bad), 128'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; gen_done = 1'b0; hash_match = 1'b0;
    charset = '0; min_len = '0; max_len = '0; hash_match_guess = '0;
    tick(2);
    check_reset_vals("rst");
    reset = 1'b0;
    tick();

    // Single length, no match: 26 guesses, 64-cycle drain.
    launch(3'd0, 5'd1, 5'd1);
    check("t1_load_busy",   128'(busy),         128'd1);
    check("t1_load_len",    128'(gen_guesslen), 128'd1);
    check("t1_load_genrst", 128'(gen_reset),    128'd1);
    tick();
    check("t1_prime_genrst", 128'(gen_reset),  128'd0);
    check("t1_prime_valid1", 128'(hash_valid), 128'd0);
    tick();
    check("t1_prime_valid2", 128'(hash_valid), 128'd0);
    tick();
    run_len(26, "t1");
    check("t1_next_genrst", 128'(gen_reset), 128'd1);
    tick(64);
    check("t1_drain_busy", 128'(busy),      128'd1);
    check("t1_drain_exh",  128'(exhausted), 128'd0);
    tick();
    check("t1_end_busy",  128'(busy),        128'd0);
    check("t1_end_exh",   128'(exhausted),   128'd1);
    check("t1_end_count", 128'(guess_count), 128'd26);

    // Two lengths: 26 + 676 guesses with a LOAD between them.
    launch(3'd0, 5'd1, 5'd2);
    check("t2_exh_clr",   128'(exhausted),   128'd0);
    check("t2_count_clr", 128'(guess_count), 128'd0);
    tick(3);
    run_len(26, "t2a");
    check("t2_next_len", 128'(gen_guesslen), 128'd1);
    tick();
    check("t2_load_genrst", 128'(gen_reset),    128'd1);
    check("t2_load_len",    128'(gen_guesslen), 128'd2);
    tick(3);
    run_len(676, "t2b");
    tick(65);
    check("t2_end_exh",   128'(exhausted),   128'd1);
    check("t2_end_count", 128'(guess_count), 128'd702);

    // Length 3 with a match; gen_done during PRIME must be ignored.
    launch(3'd0, 5'd3, 5'd3);
    check("t3_len", 128'(gen_guesslen), 128'd3);
    tick();
    gen_done = 1'b1;
    tick(2);
    gen_done = 1'b0;
    tick(10);
    hash_match = 1'b1; hash_match_guess = DOG;
    tick();
    hash_match = 1'b0; hash_match_guess = '0;
    check("t3_found",  128'(found),       128'd1);
    check("t3_fguess", found_guess,       DOG);
    check("t3_busy",   128'(busy),        128'd0);
    check("t3_exh",    128'(exhausted),   128'd0);
    check("t3_valid",  128'(hash_valid),  128'd0);
    check("t3_count",  128'(guess_count), 128'd11);
    hash_match = 1'b1; hash_match_guess = CAT;
    tick();
    hash_match = 1'b0; hash_match_guess = '0;
    check("t3_second_fguess", found_guess,  DOG);
    check("t3_second_found",  128'(found),  128'd1);

    // Illegal jobs set error; a legal one clears it. Then stop mid-RUN.
    launch(3'd0, 5'd5, 5'd3);
    check("t4_err_range", 128'(error), 128'd1);
    check("t4_err_busy",  128'(busy),  128'd0);
    check("t4_err_found", 128'(found), 128'd1);
    launch(3'd6, 5'd1, 5'd1);
    check("t4_err_cset", 128'(error), 128'd1);
    launch(3'd1, 5'd2, 5'd2);
    check("t4_err_clr",   128'(error),       128'd0);
    check("t4_found_clr", 128'(found),       128'd0);
    check("t4_cset",      128'(gen_charset), 128'd1);
    check("t4_busy",      128'(busy),        128'd1);
    tick(3);
    tick(5);
    start = 1'b1; charset = 3'd7;
    tick();
    start = 1'b0;
    check("t4_busy_start_err",  128'(error), 128'd0);
    check("t4_busy_start_busy", 128'(busy),  128'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t4_stop_busy",   128'(busy),        128'd0);
    check("t4_stop_genrst", 128'(gen_reset),   128'd1);
    check("t4_stop_count",  128'(guess_count), 128'd7);
    tick(3);
    check("t4_stop_frozen", 128'(guess_count), 128'd7);
    check("t4_stop_exh",    128'(exhausted),   128'd0);

    // Reset mid-DRAIN beats a simultaneous match.
    launch(3'd0, 5'd1, 5'd1);
    tick(3);
    run_len(26, "t5");
    tick(10);
    reset = 1'b1; hash_match = 1'b1; hash_match_guess = CAT;
    tick();
    reset = 1'b0; hash_match = 1'b0; hash_match_guess = '0;
    check_reset_vals("t5");

    // Match on the last DRAIN cycle wins over exhaustion.
    launch(3'd0, 5'd1, 5'd1);
    tick(3);
    run_len(26, "t6");
    tick(64);
    check("t6_last_drain_busy", 128'(busy), 128'd1);
    hash_match = 1'b1; hash_match_guess = ZZ;
    tick();
    hash_match = 1'b0; hash_match_guess = '0;
    check("t6_found",  128'(found),     128'd1);
    check("t6_exh",    128'(exhausted), 128'd0);
    check("t6_fguess", found_guess,     ZZ);
    check("t6_busy",   128'(busy),      128'd0);
    tick();
    check("t6_exh_hold", 128'(exhausted), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
